// File: rtl/codec_init_seq_if.sv
// Handshake bundle between the codec init sequencer (master) and the I2C byte-write engine (slave).
interface codec_init_seq_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       nack;
  logic [6:0] dev_addr;
  logic [7:0] byte0;
  logic [7:0] byte1;

  modport master (output start, dev_addr, byte0, byte1, input busy, done, nack);
  modport slave  (input start, dev_addr, byte0, byte1, output busy, done, nack);
endinterface

// File: rtl/codec_init_seq.sv
// Power-up register write sequencer for a WM8731-style codec; retries NACKed writes, then flags done/error.
// Optional macro CODEC_INIT_VOL_EN: live headphone volume (entries 3/4) with re-write on change in DONE.
module codec_init_seq #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
`ifdef CODEC_INIT_VOL_EN
  input  logic [6:0]       i_hp_vol,
`endif
  codec_init_seq_if.master i2c,
  output logic [3:0]       o_index,
  output logic             o_busy,
  output logic             o_init_done,
  output logic             o_init_error
);
  localparam int          GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERROR} state_t;

  state_t        r_state, w_state_next;
  logic [3:0]    r_index, w_index_next;
  logic [2:0]    r_retry, w_retry_next;
  logic          r_retry_pend, w_retry_pend_next;
  logic          r_restart, w_restart_next;
  logic [GW-1:0] r_gap, w_gap_next;
  logic [7:0]    r_byte0, w_byte0_next;
  logic [7:0]    r_byte1, w_byte1_next;
  logic          r_done, w_done_next;
  logic          r_error, w_error_next;
  logic [6:0]    r_dev_addr;
  logic [15:0]   w_entry;
  logic [3:0]    w_last_idx;
  logic          w_issue;
  logic          w_go_restart;
  logic          w_active;
`ifdef CODEC_INIT_VOL_EN
  logic [6:0]    r_vol, w_vol_next;
  logic          r_vol_upd, w_vol_upd_next;
`endif

  // {reg_addr[6:0], data[8:0]}
  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = {7'd15, 9'h000};
      4'd1:    table_entry = {7'd0,  9'h017};
      4'd2:    table_entry = {7'd1,  9'h017};
      4'd3:    table_entry = {7'd2,  9'h079};
      4'd4:    table_entry = {7'd3,  9'h079};
      4'd5:    table_entry = {7'd4,  9'h012};
      4'd6:    table_entry = {7'd5,  9'h000};
      4'd7:    table_entry = {7'd6,  9'h000};
      4'd8:    table_entry = {7'd7,  9'h002};
      4'd9:    table_entry = {7'd9,  9'h001};
      default: table_entry = 16'h0000;
    endcase
  endfunction

  always_comb begin
    w_entry    = table_entry(r_index);
    w_last_idx = 4'd9;
`ifdef CODEC_INIT_VOL_EN
    if (r_index == 4'd3)      w_entry = {7'd2, 2'b01, i_hp_vol};
    else if (r_index == 4'd4) w_entry = {7'd3, 2'b01, r_vol};
    if (r_vol_upd) w_last_idx = 4'd4;
`endif
  end

  assign w_active = (r_state == S_LOAD) || (r_state == S_ISSUE) ||
                    (r_state == S_WAIT) || (r_state == S_GAP);

  always_comb begin
    w_state_next      = r_state;
    w_index_next      = r_index;
    w_retry_next      = r_retry;
    w_retry_pend_next = r_retry_pend;
    w_restart_next    = r_restart;
    w_gap_next        = r_gap;
    w_byte0_next      = r_byte0;
    w_byte1_next      = r_byte1;
    w_done_next       = r_done;
    w_error_next      = r_error;
    w_issue           = 1'b0;
    w_go_restart      = 1'b0;
`ifdef CODEC_INIT_VOL_EN
    w_vol_next        = r_vol;
    w_vol_upd_next    = r_vol_upd;
`endif
    // A start while active is held until no transaction is in flight.
    if (i_start && w_active) w_restart_next = 1'b1;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start || r_restart) w_go_restart = 1'b1;
`ifdef CODEC_INIT_VOL_EN
        else if (r_state == S_DONE && i_hp_vol != r_vol) begin
          w_vol_upd_next = 1'b1;
          w_index_next   = 4'd3;
          w_state_next   = S_LOAD;
        end
`endif
      end
      S_LOAD: begin
        w_byte0_next = {w_entry[15:9], w_entry[8]};
        w_byte1_next = w_entry[7:0];
`ifdef CODEC_INIT_VOL_EN
        if (r_index == 4'd3) w_vol_next = i_hp_vol;
`endif
        w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_restart) w_go_restart = 1'b1;
        else if (!i2c.busy) begin
          w_issue      = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i2c.done) begin
          w_gap_next = '0;
          if (r_restart || !i2c.nack) begin
            w_retry_next = 3'd0;
            w_state_next = S_GAP;
          end else if (r_retry < RETRY_MAX) begin
            w_retry_next      = r_retry + 3'd1;
            w_retry_pend_next = 1'b1;
            w_state_next      = S_GAP;
          end else begin
            w_error_next = 1'b1;
            w_done_next  = 1'b0;
            w_state_next = S_ERROR;
`ifdef CODEC_INIT_VOL_EN
            w_vol_upd_next = 1'b0;
`endif
          end
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_gap_next = '0;
          if (r_restart) w_go_restart = 1'b1;
          else if (r_retry_pend) begin
            w_retry_pend_next = 1'b0;
            w_state_next      = S_ISSUE;
          end else if (r_index == w_last_idx) begin
            w_done_next  = 1'b1;
            w_state_next = S_DONE;
`ifdef CODEC_INIT_VOL_EN
            w_vol_upd_next = 1'b0;
`endif
          end else begin
            w_index_next = r_index + 4'd1;
            w_state_next = S_LOAD;
          end
        end else begin
          w_gap_next = r_gap + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_go_restart) begin
      w_state_next      = S_LOAD;
      w_index_next      = 4'd0;
      w_retry_next      = 3'd0;
      w_retry_pend_next = 1'b0;
      w_restart_next    = 1'b0;
      w_gap_next        = '0;
      w_done_next       = 1'b0;
      w_error_next      = 1'b0;
`ifdef CODEC_INIT_VOL_EN
      w_vol_upd_next    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_index      <= 4'd0;
      r_retry      <= 3'd0;
      r_retry_pend <= 1'b0;
      r_restart    <= 1'b0;
      r_gap        <= '0;
      r_byte0      <= 8'h00;
      r_byte1      <= 8'h00;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_dev_addr   <= 7'h00;
`ifdef CODEC_INIT_VOL_EN
      r_vol        <= 7'h00;
      r_vol_upd    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_index      <= w_index_next;
      r_retry      <= w_retry_next;
      r_retry_pend <= w_retry_pend_next;
      r_restart    <= w_restart_next;
      r_gap        <= w_gap_next;
      r_byte0      <= w_byte0_next;
      r_byte1      <= w_byte1_next;
      r_done       <= w_done_next;
      r_error      <= w_error_next;
      r_dev_addr   <= DEV_ADDR;
`ifdef CODEC_INIT_VOL_EN
      r_vol        <= w_vol_next;
      r_vol_upd    <= w_vol_upd_next;
`endif
    end
  end

  assign i2c.start    = w_issue;
  assign i2c.dev_addr = r_dev_addr;
  assign i2c.byte0    = r_byte0;
  assign i2c.byte1    = r_byte1;
  assign o_index      = r_index;
  assign o_busy       = w_active;
  assign o_init_done  = r_done;
  assign o_init_error = r_error;
endmodule

// File: tb/tb_codec_init_seq.sv
// Bench for codec_init_seq: I2C slave model plus scoreboard of expected write transactions.
module tb_codec_init_seq;
  localparam int         GAP       = 40;
  localparam int         SLAVE_LAT = 20;
  localparam logic [6:0] ADDR      = 7'h1A;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_start = 1'b0;
  logic [3:0] o_index;
  logic       o_busy, o_init_done, o_init_error;

  codec_init_seq_if bus();

  codec_init_seq #(.DEV_ADDR(ADDR), .MAX_RETRY(3), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i2c(bus),
    .o_index(o_index), .o_busy(o_busy), .o_init_done(o_init_done), .o_init_error(o_init_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] b0;
    logic [7:0] b1;
  } txn_t;

  txn_t vec[10];
  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model and monitor
  int   nack_entry = -1;
  int   nack_n = 0;
  int   attempts[16];
  int   start_count = 0;
  int   last_start_idx = -1;
  int   last_start_cyc = 0;
  int   last_done_cyc = -100000;
  int   done_at = -1;
  int   busy_at = -1;
  logic pend_nack = 1'b0;

  initial begin
    txn_t e;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.nack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.done = 1'b0;
      bus.nack = 1'b0;
      if (cyc == busy_at) bus.busy = 1'b1;
      if (cyc == done_at) begin
        bus.done      = 1'b1;
        bus.nack      = pend_nack;
        bus.busy      = 1'b0;
        last_done_cyc = cyc;
        done_at       = -1;
      end
      #1;
      if (bus.start === 1'b1) begin
        start_count++;
        last_start_idx = int'(o_index);
        last_start_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got i2c_start idx=%0d byte0=0x%0h, expected none (cycle %0d)",
                   o_index, bus.byte0, cyc);
        end else begin
          e = exp_q.pop_front();
          $display("txn %0d: idx=%0d byte0=0x%02h byte1=0x%02h (exp idx=%0d 0x%02h 0x%02h) cycle %0d",
                   start_count, o_index, bus.byte0, bus.byte1, e.idx, e.b0, e.b1, cyc);
          chk("start_index", 32'(o_index), 32'(e.idx));
          chk("byte0", 32'(bus.byte0), 32'(e.b0));
          chk("byte1", 32'(bus.byte1), 32'(e.b1));
          chk("dev_addr", 32'(bus.dev_addr), 32'(ADDR));
          chk("gap_after_done", 32'((cyc - last_done_cyc) >= GAP), 32'd1);
        end
        attempts[o_index]++;
        pend_nack = (int'(o_index) == nack_entry) && (attempts[o_index] <= nack_n);
        busy_at   = cyc + 1;
        done_at   = cyc + SLAVE_LAT;
      end
    end
  end

  task automatic push(input int i);
    exp_q.push_back(vec[i]);
  endtask

  task automatic clear_attempts();
    for (int i = 0; i < 16; i++) attempts[i] = 0;
  endtask

  task automatic pulse_start(output int scyc);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    scyc    = cyc;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_seq_end(input string name);
    int n;
    n = 0;
    while (!(!o_busy && exp_q.size() == 0 && done_at == -1) && n < 4000) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy=%0d pending=%0d, expected sequence end", name, o_busy, exp_q.size());
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_init_done), 32'd0);
    chk({tag, "_error"}, 32'(o_init_error), 32'd0);
    chk({tag, "_index"}, 32'(o_index), 32'd0);
    chk({tag, "_i2c_start"}, 32'(bus.start), 32'd0);
    chk({tag, "_byte0"}, 32'(bus.byte0), 32'd0);
    chk({tag, "_byte1"}, 32'(bus.byte1), 32'd0);
    chk({tag, "_dev_addr"}, 32'(bus.dev_addr), 32'd0);
  endtask

  initial begin
    int scyc, n0, n;
    vec[0] = '{idx: 4'd0, b0: 8'h1E, b1: 8'h00};
    vec[1] = '{idx: 4'd1, b0: 8'h00, b1: 8'h17};
    vec[2] = '{idx: 4'd2, b0: 8'h02, b1: 8'h17};
    vec[3] = '{idx: 4'd3, b0: 8'h04, b1: 8'h79};
    vec[4] = '{idx: 4'd4, b0: 8'h06, b1: 8'h79};
    vec[5] = '{idx: 4'd5, b0: 8'h08, b1: 8'h12};
    vec[6] = '{idx: 4'd6, b0: 8'h0A, b1: 8'h00};
    vec[7] = '{idx: 4'd7, b0: 8'h0C, b1: 8'h00};
    vec[8] = '{idx: 4'd8, b0: 8'h0E, b1: 8'h02};
    vec[9] = '{idx: 4'd9, b0: 8'h12, b1: 8'h01};
    clear_attempts();

    // Reset state
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // Normal init, including start-to-first-write latency
    for (int i = 0; i < 10; i++) push(i);
    n0 = start_count;
    pulse_start(scyc);
    n = 0;
    while (start_count == n0 && n < 50) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk("first_start_latency", 32'(last_start_cyc - scyc), 32'd2);
    wait_seq_end("normal");
    chk("normal_done", 32'(o_init_done), 32'd1);
    chk("normal_error", 32'(o_init_error), 32'd0);
    chk("normal_busy", 32'(o_busy), 32'd0);
    chk("normal_index", 32'(o_index), 32'd9);
    chk("normal_count", 32'(start_count - n0), 32'd10);

    // NACK entry 5 twice, then ACK
    clear_attempts();
    nack_entry = 5;
    nack_n     = 2;
    for (int i = 0; i < 10; i++) begin
      push(i);
      if (i == 5) begin
        push(i);
        push(i);
      end
    end
    n0 = start_count;
    pulse_start(scyc);
    wait_seq_end("retry");
    chk("retry_attempts", 32'(attempts[5]), 32'd3);
    chk("retry_count", 32'(start_count - n0), 32'd12);
    chk("retry_done", 32'(o_init_done), 32'd1);
    chk("retry_error", 32'(o_init_error), 32'd0);

    // Entry 2 never acknowledges
    clear_attempts();
    nack_entry = 2;
    nack_n     = 99;
    push(0);
    push(1);
    for (int k = 0; k < 4; k++) push(2);
    pulse_start(scyc);
    wait_seq_end("exhaust");
    chk("exhaust_attempts", 32'(attempts[2]), 32'd4);
    chk("exhaust_error", 32'(o_init_error), 32'd1);
    chk("exhaust_done", 32'(o_init_done), 32'd0);
    chk("exhaust_index", 32'(o_index), 32'd2);
    n0 = start_count;
    repeat (100) @(posedge clk);
    #3;
    chk("exhaust_no_more_start", 32'(start_count - n0), 32'd0);

    // Restart during WAIT at entry 6; a second start while pending is absorbed
    clear_attempts();
    nack_entry = -1;
    nack_n     = 0;
    for (int i = 0; i < 7; i++) push(i);
    for (int i = 0; i < 10; i++) push(i);
    n0 = start_count;
    pulse_start(scyc);
    n = 0;
    while (!(last_start_idx == 6 && start_count >= n0 + 7) && n < 2000) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk("restart_reached_entry6", 32'(last_start_idx), 32'd6);
    repeat (4) @(posedge clk);
    pulse_start(scyc);
    chk("restart_flags_done", 32'(o_init_done), 32'd0);
    chk("restart_flags_error", 32'(o_init_error), 32'd0);
    repeat (2) @(posedge clk);
    pulse_start(scyc);
    wait_seq_end("restart");
    chk("restart_count", 32'(start_count - n0), 32'd17);
    chk("restart_done", 32'(o_init_done), 32'd1);
    chk("restart_error", 32'(o_init_error), 32'd0);

    // Reset pulse during WAIT; the later i2c_done must not trigger anything
    for (int i = 0; i < 10; i++) push(i);
    n0 = start_count;
    pulse_start(scyc);
    n = 0;
    while (start_count < n0 + 2 && n < 500) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk("midreset_reached_entry1", 32'(last_start_idx), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_all_zero("midreset");
    exp_q.delete();
    n0 = start_count;
    repeat (80) @(posedge clk);
    #3;
    chk("midreset_no_start", 32'(start_count - n0), 32'd0);
    chk("midreset_idle_busy", 32'(o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
